// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program-counter and instruction-fetch stage. Holds the architectural PC,
//   fetches one instruction at a time from a variable-latency instruction
//   memory, presents it to decode and advances the PC once decode acknowledges.
//   A computed next PC that is not word aligned parks the unit in a terminal
//   trap state until reset.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   PCSrc            next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JumpTarget,
//                    11 treated as PC+4
//   ImmExt           sign-extended immediate of the held instruction
//   JumpTarget       absolute jalr target
//   instr_ack        decode consumed the held instruction this cycle
//   imem_req/addr    one-cycle read request and its address
//   imem_rvalid/rdata read response
//   Instr, PC        held instruction and its address
//   PCPlus4          PC + 4 (combinational)
//   instr_valid      Instr/PC valid
//   misalign         sticky misaligned-target flag
//   retired          acknowledged-instruction count, wraps at 2^32
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP      = 'h13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] ImmExt,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             instr_ack,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] Instr,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             instr_valid,
  output logic             misalign,
  output logic [31:0]      retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_TRAP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_imem_req;
  logic [WIDTH-1:0] r_imem_addr;
  logic [WIDTH-1:0] r_instr;
  logic             r_instr_valid;
  logic             r_misalign;
  logic [31:0]      r_retired;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_next_aligned;

  // All additions wrap naturally at WIDTH bits.
  assign w_pc_plus4 = r_pc + WIDTH'(4);

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_next_pc = r_pc + ImmExt;
      2'b10:   w_next_pc = JumpTarget;
      default: w_next_pc = w_pc_plus4;  // 00 and reserved 11
    endcase
  end

  assign w_next_aligned = (w_next_pc[1:0] == 2'b00);

  // imem_req/imem_addr are registered and raised on the edge that enters REQ,
  // so the request is visible during exactly the REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr       <= NOP;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_retired     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state     <= S_REQ;
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pc;
        end
        S_REQ: begin
          r_state    <= S_WAIT;
          r_imem_req <= 1'b0;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // rvalid is deliberately not looked at here: stray responses drop.
          if (instr_ack) begin
            r_retired     <= r_retired + 32'd1;
            r_instr_valid <= 1'b0;
            r_instr       <= NOP;
            if (w_next_aligned) begin
              r_pc        <= w_next_pc;
              r_imem_addr <= w_next_pc;
              r_imem_req  <= 1'b1;
              r_state     <= S_REQ;
            end else begin
              r_misalign <= 1'b1;
              r_state    <= S_TRAP;
            end
          end
        end
        S_TRAP: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_misalign    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign Instr       = r_instr;
  assign PC          = r_pc;
  assign PCPlus4     = w_pc_plus4;
  assign instr_valid = r_instr_valid;
  assign misalign    = r_misalign;
  assign retired     = r_retired;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and instruction-fetch stage, directly upstream of the control unit and datapath.
- Holds the architectural PC and fetches from a variable-latency instruction memory over a request/response handshake.
- Presents one instruction at a time to decode, and computes the next PC from the PCSrc selector returned by the control unit.
- Adds misaligned-target detection and a retired-instruction counter.

Parameters:
- WIDTH, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, instruction value driven on Instr while no instruction is valid (addi x0,x0,0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCSrc  input  2  next-PC select from the control unit: 00 PC+4, 01 PC+ImmExt, 10 JumpTarget, 11 reserved.
- ImmExt  input  WIDTH  sign-extended immediate for the held instruction.
- JumpTarget  input  WIDTH  absolute target (ALU result) for jalr.
- instr_ack  input  1  downstream has consumed the held instruction; PCSrc, ImmExt and JumpTarget are valid this cycle.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  WIDTH  read address.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  WIDTH  read data.
- Instr  output  WIDTH  held instruction.
- PC  output  WIDTH  address of the held instruction.
- PCPlus4  output  WIDTH  PC+4, combinational from PC.
- instr_valid  output  1  Instr and PC are valid.
- misalign  output  1  sticky flag: computed next PC had bits [1:0] != 00.
- retired  output  32  count of acknowledged instructions; wraps at 2^32.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is asynchronous and active-high.
  - All state registers are reset asynchronously.
- Reset values:
  - PC=RESET_PC, imem_req=0, imem_addr=RESET_PC.
  - Instr=NOP, instr_valid=0, misalign=0, retired=0.
  - FSM=IDLE.
- FSM states are IDLE, REQ, WAIT, HOLD, TRAP.
  - IDLE: outputs quiescent. Moves to REQ on the next edge. Used only after reset.
  - REQ: imem_req=1 and imem_addr=PC for exactly one cycle, then WAIT.
  - WAIT: imem_req=0.
    - On imem_rvalid=1: capture Instr<=imem_rdata, set instr_valid<=1, go to HOLD.
    - Otherwise stay in WAIT; there is no timeout.
  - HOLD: Instr, PC and instr_valid=1 are held stable.
    - On instr_ack=1: retired<=retired+1 and instr_valid<=0.
    - NextPC is computed per the arithmetic rules below.
    - If NextPC[1:0]==00: PC<=NextPC, Instr<=NOP, go to REQ.
    - Otherwise: misalign<=1, PC unchanged, Instr<=NOP, go to TRAP.
  - TRAP: terminal. imem_req=0, instr_valid=0, misalign=1. Only reset exits.
- Latency:
  - Ack at edge N gives imem_req=1 in cycle N+1.
  - rvalid in cycle M gives instr_valid=1 in cycle M+1.
  - Minimum issue interval is 3 cycles per instruction (REQ, WAIT with rvalid, HOLD with ack).
- Arithmetic: all additions are modulo 2^WIDTH.
  - PC+4 at 32'hFFFF_FFFC wraps to 0.
  - PC+ImmExt uses two's-complement wrap.
  - PCSrc=11 behaves as 00.
- Ignored inputs:
  - imem_rvalid outside WAIT is ignored; a stale response must not alter Instr.
  - instr_ack outside HOLD is ignored, and retired does not increment.
- Simultaneous events: instr_ack and a stray imem_rvalid in the same HOLD cycle means the ack is processed and rvalid is ignored.
- Reset mid-operation:
  - Asserting rst in any state, including WAIT with an outstanding request, returns all registers to reset values immediately.
  - A response arriving after reset deassertion lands in IDLE or REQ and is dropped.
- misalign does not clear except on reset.

Test Plan:
- Reset then sequential fetch, 1-cycle memory, PCSrc=00 acked each HOLD: imem_addr sequence is 0,4,8,C; retired=4 after 4 acks; Instr equals the returned data each time.
- Branch taken: PC=0x10, PCSrc=01, ImmExt=0xFFFF_FFF8 → next imem_addr=0x08. jalr with PCSrc=10, JumpTarget=0x200 → next imem_addr=0x200.
- Variable latency: rvalid delayed 5 cycles, with stray rvalid pulses in HOLD and IDLE:
  - instr_valid rises exactly 1 cycle after the in-WAIT rvalid.
  - Instr is unchanged by the stray pulses.
  - instr_ack held high outside HOLD does not change retired.
- Misaligned target: PCSrc=10, JumpTarget=0x102:
  - misalign=1 and state is TRAP.
  - imem_req stays 0 for 20+ cycles; PC still equals the faulting instruction's PC.
  - rst clears misalign and restarts fetch at RESET_PC.
- Wrap-around:
  - PC=0xFFFF_FFFC with PCSrc=00 → next imem_addr=0.
  - retired preset via 2^32 acks is too slow to simulate; force retired=0xFFFF_FFFF and ack once → 0.
- Reset during WAIT, then the memory returns data 1 cycle after deassertion: data is dropped, the first valid Instr is the response to the new REQ at RESET_PC, and instr_valid=0 throughout reset.
